// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, widths and FSM encodings for the multiply/divide unit.
package muldiv_unit_pkg;

   localparam int unsigned ALUOP_W = 6;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned DWORD_W = 64;
   localparam int unsigned DIV_CYC = 32;

   localparam logic [ALUOP_W-1:0] ALU_NOP   = 6'h00;
   localparam logic [ALUOP_W-1:0] ALU_MULT  = 6'h10;
   localparam logic [ALUOP_W-1:0] ALU_MULTU = 6'h11;
   localparam logic [ALUOP_W-1:0] ALU_MUL   = 6'h12;
   localparam logic [ALUOP_W-1:0] ALU_MADD  = 6'h13;
   localparam logic [ALUOP_W-1:0] ALU_MADDU = 6'h14;
   localparam logic [ALUOP_W-1:0] ALU_MSUB  = 6'h15;
   localparam logic [ALUOP_W-1:0] ALU_MSUBU = 6'h16;
   localparam logic [ALUOP_W-1:0] ALU_DIV   = 6'h17;
   localparam logic [ALUOP_W-1:0] ALU_DIVU  = 6'h18;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_MUL  = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;
   localparam logic [1:0] MD_DONE = 2'd3;

   function automatic logic is_mul_op(logic [ALUOP_W-1:0] op);
      return op inside {ALU_MULT, ALU_MULTU, ALU_MUL, ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU};
   endfunction

   function automatic logic is_div_op(logic [ALUOP_W-1:0] op);
      return op inside {ALU_DIV, ALU_DIVU};
   endfunction

   function automatic logic is_signed_op(logic [ALUOP_W-1:0] op);
      return op inside {ALU_MULT, ALU_MUL, ALU_MADD, ALU_MSUB, ALU_DIV};
   endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring radix-2 divider core on unsigned magnitudes, one quotient bit per cycle.
module muldiv_unit_div_iter
   import muldiv_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        start_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] q_o,
   output logic [31:0] r_o
);

   logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [32:0] trial, diff;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dsr_d  = dsr_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      trial  = {rem_q, quo_q[31]};
      diff   = trial - {1'b0, dsr_q};
      if (flush_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         rem_d  = '0;
         quo_d  = dividend_i;
         dsr_d  = divisor_i;
         cnt_d  = 6'(DIV_CYC);
         busy_d = 1'b1;
      end else if (busy_q) begin
         // diff[32] is the borrow: set means the trial subtraction must be undone
         rem_d = diff[32] ? trial[31:0] : diff[31:0];
         quo_d = {quo_q[30:0], ~diff[32]};
         cnt_d = cnt_q - 6'd1;
         if (cnt_q == 6'd1) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dsr_q  <= dsr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign q_o    = quo_q;
   assign r_o    = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage; produces {hi,lo} or {remainder,quotient}.
// Define MULDIV_DIV_EN to build the divider; otherwise div-class ops return 0 after one cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [ALUOP_W-1:0]  aluop,
   input  logic [WORD_W-1:0]   srcA,
   input  logic [WORD_W-1:0]   srcB,
   output logic                stallreq,
   output logic                res_vld,
   output logic [DWORD_W-1:0]  mdres
);

   logic [1:0]  state_q, state_d;
   logic        mul_ph_q, mul_ph_d;
   logic        neg_q, neg_d;
   logic [63:0] mdres_q, mdres_d;
   logic [31:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
   logic        is_mul, is_div, sgn;
   logic [31:0] a_mag, b_mag;
   logic [63:0] prod_mag, prod;

   assign is_mul = is_mul_op(aluop);
   assign is_div = is_div_op(aluop);
   assign sgn    = is_signed_op(aluop);
   assign a_mag  = (sgn && srcA[31]) ? (~srcA + 32'd1) : srcA;
   assign b_mag  = (sgn && srcB[31]) ? (~srcB + 32'd1) : srcB;

   assign prod_mag = {pp_hh_q, pp_ll_q} + {16'd0, pp_lh_q, 16'd0} + {16'd0, pp_hl_q, 16'd0};
   assign prod     = neg_q ? (~prod_mag + 64'd1) : prod_mag;

`ifdef MULDIV_DIV_EN
   logic        div_start, div_busy, div_done;
   logic [31:0] div_q, div_r, q_fix, r_fix;
   logic        rneg_q, rneg_d;

   assign q_fix = neg_q ? (~div_q + 32'd1) : div_q;
   assign r_fix = rneg_q ? (~div_r + 32'd1) : div_r;

   muldiv_unit_div_iter u_div_iter (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .start_i    (div_start),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .q_o        (div_q),
      .r_o        (div_r)
   );
`endif

   always_comb begin
      state_d  = state_q;
      mul_ph_d = mul_ph_q;
      neg_d    = neg_q;
      mdres_d  = mdres_q;
`ifdef MULDIV_DIV_EN
      div_start = 1'b0;
      rneg_d    = rneg_q;
`endif
      case (state_q)
         MD_IDLE: begin
            if (is_mul) begin
               state_d  = MD_MUL;
               mul_ph_d = 1'b0;
               neg_d    = sgn & (srcA[31] ^ srcB[31]);
            end else if (is_div) begin
`ifdef MULDIV_DIV_EN
               if (srcB == 32'd0) begin
                  state_d = MD_DONE;
                  mdres_d = {srcA, 32'hFFFF_FFFF};
               end else begin
                  state_d   = MD_DIV;
                  div_start = 1'b1;
                  neg_d     = sgn & (srcA[31] ^ srcB[31]);
                  rneg_d    = sgn & srcA[31];
               end
`else
               state_d = MD_DONE;
               mdres_d = '0;
`endif
            end
         end
         MD_MUL: begin
            if (!mul_ph_q) begin
               mul_ph_d = 1'b1;
            end else begin
               mdres_d = prod;
               state_d = MD_DONE;
            end
         end
         MD_DIV: begin
`ifdef MULDIV_DIV_EN
            if (div_done) begin
               mdres_d = {r_fix, q_fix};
               state_d = MD_DONE;
            end else if (!div_busy) begin
               state_d = MD_IDLE;
            end
`else
            state_d = MD_IDLE;
`endif
         end
         default: state_d = MD_IDLE;
      endcase
      // A flush abandons the op without touching the held result
      if (flush) begin
         state_d = MD_IDLE;
         mdres_d = mdres_q;
`ifdef MULDIV_DIV_EN
         div_start = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MD_IDLE;
         mul_ph_q <= 1'b0;
         neg_q    <= 1'b0;
         mdres_q  <= '0;
         pp_ll_q  <= '0;
         pp_lh_q  <= '0;
         pp_hl_q  <= '0;
         pp_hh_q  <= '0;
      end else begin
         state_q  <= state_d;
         mul_ph_q <= mul_ph_d;
         neg_q    <= neg_d;
         mdres_q  <= mdres_d;
         if (state_q == MD_MUL && !mul_ph_q) begin
            pp_ll_q <= {16'd0, a_mag[15:0]}  * {16'd0, b_mag[15:0]};
            pp_lh_q <= {16'd0, a_mag[15:0]}  * {16'd0, b_mag[31:16]};
            pp_hl_q <= {16'd0, a_mag[31:16]} * {16'd0, b_mag[15:0]};
            pp_hh_q <= {16'd0, a_mag[31:16]} * {16'd0, b_mag[31:16]};
         end
      end
   end

`ifdef MULDIV_DIV_EN
   always_ff @(posedge clk) begin
      if (rst) rneg_q <= 1'b0;
      else     rneg_q <= rneg_d;
   end
`endif

   assign stallreq = !rst && !flush &&
                     ((state_q == MD_IDLE && (is_mul || is_div)) ||
                      state_q == MD_MUL || state_q == MD_DIV);
   assign res_vld  = !rst && !flush && (state_q == MD_DONE);
   assign mdres    = mdres_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: latency/result model plus hand-computed vectors.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk, rst, flush;
   logic [5:0]  aluop;
   logic [31:0] srcA, srcB;
   logic        stallreq, res_vld;
   logic [63:0] mdres;

   int          n_chk, n_fail;
   bit          chk_en, act, skip_md;
   int          age, exp_lat;
   logic [63:0] exp_res, last_res;

   muldiv_unit dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .aluop    (aluop),
      .srcA     (srcA),
      .srcB     (srcB),
      .stallreq (stallreq),
      .res_vld  (res_vld),
      .mdres    (mdres)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic bit tb_is_div(input logic [5:0] op);
      return (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

   // Expected result from plain arithmetic on the operands
   function automatic logic [63:0] model_res(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         ALU_MULT, ALU_MUL, ALU_MADD, ALU_MSUB: return 64'(sa * sb);
         ALU_MULTU, ALU_MADDU, ALU_MSUBU:       return {32'd0, a} * {32'd0, b};
         default: begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == ALU_DIV) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
`else
            return 64'd0;
`endif
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [5:0] op, input logic [31:0] b);
      if (!tb_is_div(op)) return 3;
`ifdef MULDIV_DIV_EN
      if (b == 32'd0) return 1;
      return int'(DIV_CYC) + 2;
`else
      return (b == 32'd0) ? 1 : 1;
`endif
   endfunction

   function automatic logic [63:0] dl(input logic [63:0] x);
`ifdef MULDIV_DIV_EN
      return x;
`else
      return 64'd0;
`endif
   endfunction

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("stallreq", 64'(stallreq), 64'(act && (age < exp_lat)));
         check("res_vld", 64'(res_vld), 64'(act && (age == exp_lat)));
         if (act && age == exp_lat) begin
            check("mdres", mdres, exp_res);
            last_res = exp_res;
         end else if (!skip_md) begin
            check("mdres_hold", mdres, last_res);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      aluop   = op;
      srcA    = a;
      srcB    = b;
      act     = 1'b1;
      age     = 0;
      exp_lat = model_lat(op, b);
      exp_res = model_res(op, a, b);
   endtask

   task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit use_lit, input logic [63:0] lit);
      start_op(op, a, b);
      for (int k = 0; k < exp_lat; k++) begin
         @(posedge clk);
         #1 age++;
      end
      @(negedge clk);
      if (use_lit) check(nm, mdres, lit);
      @(posedge clk);
      #1;
      act   = 1'b0;
      aluop = ALU_NOP;
      srcA  = '0;
      srcB  = '0;
   endtask

   task automatic run_flush(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int at);
      start_op(op, a, b);
      repeat (at) begin
         @(posedge clk);
         #1 age++;
      end
      // Result is already latched once DONE is reached; only res_vld is suppressed
      if (at == exp_lat) last_res = exp_res;
      flush = 1'b1;
      act   = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      aluop = ALU_NOP;
      srcA  = '0;
      srcB  = '0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; aluop = ALU_NOP; srcA = '0; srcB = '0;
      n_chk = 0; n_fail = 0; chk_en = 1'b0; act = 1'b0; skip_md = 1'b0;
      age = 0; exp_lat = 0; exp_res = '0; last_res = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      idle(2);

      run_op("mult_m1x2", ALU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("multu_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
      run_op("mul_m3x7", ALU_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("maddu", ALU_MADDU, 32'h8000_0000, 32'h0000_0002, 1'b1, 64'h0000_0001_0000_0000);
      run_op("msub_min2", ALU_MSUB, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      run_op("msubu", ALU_MSUBU, 32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000);
      run_op("madd_mix", ALU_MADD, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '0);
      idle(1);

      run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1,
             dl(64'hFFFF_FFFF_FFFF_FFFD));
      run_op("divu_by0", ALU_DIVU, 32'h0000_0064, 32'h0000_0000, 1'b1,
             dl(64'h0000_0064_FFFF_FFFF));
      run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
             dl(64'h0000_0000_8000_0000));
      run_op("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1,
             dl(64'h0000_000F_0FFF_FFFF));
      run_op("div_100_m7", ALU_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 1'b1,
             dl(64'h0000_0002_FFFF_FFF2));
      run_op("div_9_3", ALU_DIV, 32'h0000_0009, 32'h0000_0003, 1'b1,
             dl(64'h0000_0000_0000_0003));
      idle(2);

`ifdef MULDIV_DIV_EN
      run_flush(ALU_DIV, 32'h0000_1000, 32'h0000_0003, 10);
`else
      run_flush(ALU_MULT, 32'h0000_1000, 32'h0000_0003, 1);
`endif
      idle(2);
      run_op("mult_3x5", ALU_MULT, 32'h0000_0003, 32'h0000_0005, 1'b1, 64'd15);
      run_flush(ALU_MULTU, 32'h0000_0100, 32'h0000_0100, 3);
      idle(2);

      start_op(ALU_MULT, 32'h0000_0007, 32'h0000_0009);
      @(posedge clk);
      #1 age++;
      rst = 1'b1; act = 1'b0; skip_md = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; aluop = ALU_NOP; srcA = '0; srcB = '0; last_res = '0; skip_md = 1'b0;
      idle(2);

      run_op("b2b_a", ALU_MULTU, 32'h0000_0010, 32'h0000_0020, 1'b1, 64'h0000_0000_0000_0200);
      run_op("b2b_b", ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
